// File: rtl/pps_tod_transmitter_if.sv
// Bundle between the taming timer and the PPS/ToD transmitter.
// master: drives epoch/lock/pps_en and observes pulse, serial line and status.
// slave : the transmitter side (consumes epoch/lock/pps_en, drives the outputs).
interface pps_tod_transmitter_if;
  logic [31:0] epoch;        // current epoch in seconds
  logic        lock;         // taming lock status
  logic        pps_en;       // 1 = act on epoch changes
  logic        pps_out;      // regenerated PPS pulse
  logic        tx;           // serial ToD line, idle high
  logic        tx_busy;      // frame on the line
  logic        msg_dropped;  // one-cycle pulse: frame dropped while busy

  modport master (
    output epoch, lock, pps_en,
    input  pps_out, tx, tx_busy, msg_dropped
  );

  modport slave (
    input  epoch, lock, pps_en,
    output pps_out, tx, tx_busy, msg_dropped
  );
endinterface

// File: rtl/pps_tod_transmitter.sv
// Purpose : regenerate PPS from epoch changes and send a 7-byte ToD frame on a UART-style line.
// Latency : pps_out and the start bit of a frame appear one cycle after the epoch change.
// Backpr. : none; an event arriving while a frame is on the line is dropped (msg_dropped pulse).
//
// Ports:
//   clk_in  - system clock          reset - synchronous, active-high
//   tod     - pps_tod_transmitter_if.slave (epoch, lock, pps_en in; pps_out, tx, tx_busy,
//             msg_dropped out)
// Optional feature: define TOD_PARITY_EN to insert an even-parity bit after data bit 7
// (11 bits per byte instead of 8N1).
module pps_tod_transmitter #(
  parameter int         PPS_WIDTH = 10,
  parameter int         BAUD_DIV  = 87,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic                 clk_in,
  input  logic                 reset,
  pps_tod_transmitter_if.slave tod
);

  localparam int             BW         = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int             PW         = $clog2(PPS_WIDTH + 1);
  localparam logic [BW-1:0]  BAUD_LAST  = BW'(BAUD_DIV - 1);
  localparam logic [PW-1:0]  PPS_LOAD   = PW'(PPS_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic [PW-1:0] pps_cnt_q, pps_cnt_d;
  logic [31:0]   epoch_q;
  logic [31:0]   frame_epoch_q;
  logic          lock_q;
  logic          drop_q;

  logic          evt;
  logic          frame_busy;
  logic          latch;
  logic          baud_end;
  logic [7:0]    chk;
  logic [7:0]    cur_byte;
  logic          tx_d;

  // Any epoch difference is an event, including holdover jumps.
  assign evt        = (tod.epoch != epoch_q) && tod.pps_en;
  assign frame_busy = (state_q != IDLE);
  assign latch      = evt && !frame_busy;
  assign baud_end   = (baud_q == BAUD_LAST);

  // Checksum covers the lock byte and the four epoch bytes, not the sync byte.
  assign chk = {7'b0, lock_q} ^ frame_epoch_q[31:24] ^ frame_epoch_q[23:16]
             ^ frame_epoch_q[15:8] ^ frame_epoch_q[7:0];

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_q)
      3'd1:    cur_byte = {7'b0, lock_q};
      3'd2:    cur_byte = frame_epoch_q[31:24];
      3'd3:    cur_byte = frame_epoch_q[23:16];
      3'd4:    cur_byte = frame_epoch_q[15:8];
      3'd5:    cur_byte = frame_epoch_q[7:0];
      3'd6:    cur_byte = chk;
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    if (state_q == IDLE) begin
      if (latch) begin
        state_d = START;
        baud_d  = '0;
        bit_d   = '0;
        byte_d  = '0;
      end
    end else begin
      baud_d = baud_end ? '0 : baud_q + BW'(1);
      if (baud_end) begin
        case (state_q)
          START: begin
            state_d = DATA;
            bit_d   = '0;
          end
          DATA: begin
            if (bit_q == 3'd7) begin
`ifdef TOD_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
          PARITY: state_d = STOP;
          STOP: begin
            // Bytes go back-to-back: the next start bit follows the stop bit directly.
            if (byte_q < 3'd6) begin
              state_d = START;
              byte_d  = byte_q + 3'd1;
            end else begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // FSM outputs
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_q];
      PARITY:  tx_d = ^cur_byte;     // even parity over data + parity bit
      default: tx_d = 1'b1;
    endcase
  end

  // A reload on a new event stretches a pulse already in progress.
  always_comb begin
    pps_cnt_d = pps_cnt_q;
    if (evt) begin
      pps_cnt_d = PPS_LOAD;
    end else if (pps_cnt_q != '0) begin
      pps_cnt_d = pps_cnt_q - PW'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    // Tracking epoch through reset keeps the release from looking like an event.
    epoch_q <= tod.epoch;
    if (reset) begin
      pps_cnt_q     <= '0;
      drop_q        <= 1'b0;
      lock_q        <= 1'b0;
      frame_epoch_q <= '0;
    end else begin
      pps_cnt_q <= pps_cnt_d;
      drop_q    <= evt && frame_busy;
      if (latch) begin
        lock_q        <= tod.lock;
        frame_epoch_q <= tod.epoch;
      end
    end
  end

  assign tod.pps_out     = (pps_cnt_q != '0);
  assign tod.tx          = tx_d;
  assign tod.tx_busy     = frame_busy;
  assign tod.msg_dropped = drop_q;

endmodule
